// File: rtl/booth_mul32_if.sv
// Handshake and data bus for the 32x32 signed Booth multiplier.
// The master issues start/clear with operands; the slave returns the
// registered product, a one-cycle load strobe and a done level.
interface booth_mul32_if;
    logic        op_start;
    logic        op_clear;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] result;
    logic        result_en;
    logic        op_done;

    modport master (
        output op_start,
        output op_clear,
        output multiplicand,
        output multiplier,
        input  result,
        input  result_en,
        input  op_done
    );

    modport slave (
        input  op_start,
        input  op_clear,
        input  multiplicand,
        input  multiplier,
        output result,
        output result_en,
        output op_done
    );
endinterface

// File: rtl/booth_mul32.sv
// Sequential radix-2 Booth multiplier, 32x32 signed -> 64-bit product.
// One Booth step per EXEC cycle on {U,L,q}; U is 33 bits wide so that
// subtracting A = -2^31 cannot overflow. The product {U[31:0],L} is
// captured into the result register on completion with a one-cycle
// result_en strobe for the downstream enabled register.
module booth_mul32 (
    input  logic          clk,
    input  logic          reset_n,
    booth_mul32_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q,     state_d;
    logic [31:0] a_q,         a_d;
    logic [32:0] u_q,         u_d;
    logic [31:0] l_q,         l_d;
    logic        q_q,         q_d;
    logic [5:0]  cnt_q,       cnt_d;
    logic [63:0] result_q,    result_d;
    logic        result_en_q, result_en_d;

    logic [32:0] a_ext;
    logic [32:0] u_sum;

    // Booth add/subtract of the sign-extended multiplicand selected by {L[0],q}
    always_comb begin
        a_ext = {a_q[31], a_q};
        case ({l_q[0], q_q})
            2'b01:   u_sum = u_q + a_ext;
            2'b10:   u_sum = u_q - a_ext;
            default: u_sum = u_q;
        endcase
    end

    // Next-state logic: clear beats start; start accepted in IDLE and DONE only
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        u_d         = u_q;
        l_d         = l_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_en_d = 1'b0;

        if (bus.op_clear) begin
            state_d  = ST_IDLE;
            result_d = 64'h0;
            u_d      = 33'h0;
            l_d      = 32'h0;
            q_d      = 1'b0;
            cnt_d    = 6'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.op_start) begin
                        a_d     = bus.multiplicand;
                        u_d     = 33'h0;
                        l_d     = bus.multiplier;
                        q_d     = 1'b0;
                        cnt_d   = 6'd0;
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q[5]) begin
                        // All 32 steps done: publish the product
                        state_d     = ST_DONE;
                        result_d    = {u_q[31:0], l_q};
                        result_en_d = 1'b1;
                    end else begin
                        // Arithmetic right shift of {U,L,q}, U sign replicated
                        u_d   = {u_sum[32], u_sum[32:1]};
                        l_d   = {u_sum[0], l_q[31:1]};
                        q_d   = l_q[0];
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            a_q         <= 32'h0;
            u_q         <= 33'h0;
            l_q         <= 32'h0;
            q_q         <= 1'b0;
            cnt_q       <= 6'd0;
            result_q    <= 64'h0;
            result_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            u_q         <= u_d;
            l_q         <= l_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_en_q <= result_en_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.result_en = result_en_q;
    assign bus.op_done   = (state_q == ST_DONE);
endmodule

// File: tb/tb_booth_mul32.sv
// Self-checking bench for booth_mul32: directed products from the
// requirement examples, random operands against a plain-arithmetic
// signed product, and clear/reset/restart sequencing.
module tb_booth_mul32;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    logic [63:0] last_result;

    booth_mul32_if bus ();

    booth_mul32 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation: start sampled at edge N, product expected at N+33
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        logic        saw_en;
        logic        saw_done;
        logic        held;
        exp = ref_mul(a, b);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.op_start     = 1'b1;
        tick();
        bus.op_start = 1'b0;
        check("done_falls_on_start", {63'h0, bus.op_done}, 64'h0);
        saw_en = 1'b0; saw_done = 1'b0; held = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            saw_en   |= bus.result_en;
            saw_done |= bus.op_done;
            if (bus.result !== last_result) held = 1'b0;
        end
        check("no_en_during_exec", {63'h0, saw_en}, 64'h0);
        check("no_done_during_exec", {63'h0, saw_done}, 64'h0);
        check("result_held_exec", {63'h0, held}, 64'h1);
        tick();
        check("product", bus.result, exp);
        check("result_en_pulse", {63'h0, bus.result_en}, 64'h1);
        check("op_done_high", {63'h0, bus.op_done}, 64'h1);
        last_result = exp;
        tick();
        check("result_en_single", {63'h0, bus.result_en}, 64'h0);
        check("product_held_done", bus.result, exp);
        $display("op a=%h b=%h result=%h expected=%h", a, b, bus.result, exp);
    endtask

    initial begin
        logic        saw_en;
        logic        saw_done;
        logic        zero_ok;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0;
        failures = 0;
        last_result = 64'h0;
        reset_n = 1'b0;
        bus.op_start = 1'b0;
        bus.op_clear = 1'b0;
        bus.multiplicand = 32'h0;
        bus.multiplier = 32'h0;
        tick();
        tick();
        check("reset_result", bus.result, 64'h0);
        check("reset_en", {63'h0, bus.result_en}, 64'h0);
        check("reset_done", {63'h0, bus.op_done}, 64'h0);
        reset_n = 1'b1;
        tick();

        // Directed examples, back to back so each restarts from DONE
        run_op(32'd3, 32'd5);
        check("3x5", bus.result, 64'h0000_0000_0000_000F);
        run_op(32'hFFFF_FFFF, 32'd2);
        check("m1x2", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(-32'sd7, 32'd6);
        check("m7x6", bus.result, 64'hFFFF_FFFF_FFFF_FFD6);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("m1xm1", bus.result, 64'h1);
        run_op(32'h8000_0000, 32'h8000_0000);
        check("minxmin", bus.result, 64'h4000_0000_0000_0000);
        run_op(32'h7FFF_FFFF, 32'h8000_0000);
        check("maxxmin", bus.result, 64'hC000_0000_8000_0000);

        // Random operands
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb);
        end

        // op_start during EXEC is ignored
        bus.multiplicand = 32'd3; bus.multiplier = 32'd5; bus.op_start = 1'b1;
        tick();
        bus.op_start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (k == 5) begin
                bus.multiplicand = 32'd100; bus.multiplier = 32'd100; bus.op_start = 1'b1;
            end
            tick();
            bus.op_start = 1'b0;
        end
        tick();
        check("start_ignored_exec", bus.result, 64'd15);
        check("start_ignored_en", {63'h0, bus.result_en}, 64'h1);
        last_result = 64'd15;
        tick();
        $display("exec-start-ignored result=%h", bus.result);

        // Clear mid-EXEC at N+10: no result_en through N+40
        bus.multiplicand = 32'd3; bus.multiplier = 32'd5; bus.op_start = 1'b1;
        tick();
        bus.op_start = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        bus.op_clear = 1'b1;
        tick();
        bus.op_clear = 1'b0;
        check("clear_result", bus.result, 64'h0);
        check("clear_done", {63'h0, bus.op_done}, 64'h0);
        saw_en = 1'b0; saw_done = 1'b0;
        for (int k = 11; k <= 40; k++) begin
            tick();
            saw_en   |= bus.result_en;
            saw_done |= bus.op_done;
        end
        check("clear_no_en", {63'h0, saw_en}, 64'h0);
        check("clear_no_done", {63'h0, saw_done}, 64'h0);
        last_result = 64'h0;
        $display("clear-mid-exec result=%h", bus.result);

        // Reset mid-EXEC at N+20, after a completed op left result nonzero
        run_op(32'd3, 32'd5);
        bus.multiplicand = 32'd3; bus.multiplier = 32'd5; bus.op_start = 1'b1;
        tick();
        bus.op_start = 1'b0;
        for (int k = 1; k <= 19; k++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        zero_ok = (bus.result === 64'h0) && (bus.result_en === 1'b0) && (bus.op_done === 1'b0);
        check("reset_mid_exec_zero", {63'h0, zero_ok}, 64'h1);
        saw_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            saw_en |= bus.result_en;
        end
        check("reset_no_en", {63'h0, saw_en}, 64'h0);
        last_result = 64'h0;
        run_op(32'd2, 32'd2);
        check("restart_2x2", bus.result, 64'd4);

        // Clear wins over start in the same cycle (from DONE)
        bus.multiplicand = 32'd5; bus.multiplier = 32'd5;
        bus.op_start = 1'b1; bus.op_clear = 1'b1;
        tick();
        bus.op_start = 1'b0; bus.op_clear = 1'b0;
        check("clear_prio_result", bus.result, 64'h0);
        check("clear_prio_done", {63'h0, bus.op_done}, 64'h0);
        saw_en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            saw_en |= bus.result_en;
        end
        check("clear_prio_no_en", {63'h0, saw_en}, 64'h0);
        last_result = 64'h0;

        // Reset wins over start and clear
        run_op(32'd6, 32'd7);
        bus.op_start = 1'b1; bus.op_clear = 1'b1; reset_n = 1'b0;
        tick();
        bus.op_start = 1'b0; bus.op_clear = 1'b0; reset_n = 1'b1;
        check("reset_prio_result", bus.result, 64'h0);
        check("reset_prio_done", {63'h0, bus.op_done}, 64'h0);
        saw_en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            saw_en |= bus.result_en;
        end
        check("reset_prio_no_en", {63'h0, saw_en}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
